l1_cache_control: RTL and testbench
===================================

Name: l1_cache_control

Overview:
- FSM sequencer for the direct-mapped L1 cache datapath (16 sets × 256-bit lines, 23-bit tag, valid/dirty per set).
- Accepts CPU read/write requests and decides hit/miss from the datapath `hit` and `dirty_out`.
- On a miss, performs a write-back of the dirty victim, then a line fill, through a one-outstanding-request pmem handshake.
- Drives all datapath load/select controls.

Parameters:
CNT_W, 32, width of each performance counter (used only when L1_CTRL_PERF_EN is defined)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_resp  out  1  one-cycle completion pulse to the CPU
hit  in  1  datapath: valid && tag match for the current index
dirty_out  in  1  datapath: dirty bit of the current index
tag_load  out  1  load address tag into the tag array
valid_load  out  1  set valid for the current index
dirty_load  out  1  write dirty_in into the dirty array
dirty_in  out  1  dirty value to write
writing  out  2  00 = fill from pmem, 01 = CPU byte-masked write, 10 = hold line
pmem_read  out  1  pmem line-read request, held until pmem_resp
pmem_write  out  1  pmem line-write request, held until pmem_resp
pmem_resp  in  1  pmem completion pulse
hit_count  out  CNT_W  requests completed as hits
miss_count  out  CNT_W  requests that missed
wb_count  out  CNT_W  write-backs issued

Behaviour:
- States: IDLE, WRITEBACK, FILL. Next-state is registered; outputs are combinational from state and inputs (Mealy).
- Reset (rst=0, any state, including mid-transaction):
  - State → IDLE.
  - All outputs 0 except writing = 10.
  - Any pmem transaction in flight is abandoned, not completed.
- Defaults in every state unless overridden: all loads 0, dirty_in 0, writing 10, mem_resp 0, pmem_read/pmem_write 0.
- If mem_read and mem_write are both 1, the request is treated as a write.
- IDLE, no request: stay in IDLE.
- IDLE, request with hit=1, same cycle (0-wait hit):
  - mem_resp = 1.
  - On write: writing = 01, dirty_load = 1, dirty_in = 1.
  - Stay in IDLE.
- IDLE, request with hit=0:
  - Go to WRITEBACK if dirty_out = 1, else to FILL.
  - miss_count increments once here.
- WRITEBACK:
  - pmem_write = 1; the datapath presents the victim address {tag_out, index, 0} and the victim line.
  - On pmem_resp: dirty_load = 1, dirty_in = 0, go to FILL.
  - Clearing dirty makes the datapath switch pmem_address to the CPU address before FILL begins.
- FILL:
  - pmem_read = 1; writing = 10 while waiting.
  - On pmem_resp, same cycle: writing = 00, tag_load = 1, valid_load = 1, dirty_load = 1, dirty_in = 0. Go to IDLE.
  - IDLE then re-evaluates the still-held request, now a hit, and completes it, including the CPU write merge.
- Latency, from request-assert cycle to mem_resp:
  - Hit: 0 cycles.
  - Clean miss: Tfill + 1.
  - Dirty miss: Twb + Tfill + 1.
- Boundary conditions:
  - pmem_resp in IDLE is ignored.
  - pmem_read and pmem_write are never both 1.
  - A CPU request withdrawn mid-miss does not abort the miss: the fill completes and IDLE then sees no request.
  - The address must stay stable while a request is held; this is CPU protocol and is not checked by this block.

Optional Feature:
- Macro: L1_CTRL_PERF_EN.
- Defined: three saturating counters of CNT_W bits, reset to 0:
  - hit_count increments on each mem_resp for a request that did not miss.
  - miss_count increments on each IDLE → WRITEBACK/FILL transition.
  - wb_count increments on each WRITEBACK pmem_resp.
  - Each counter holds at all-ones.
- Undefined: the counter ports remain and are tied to 0; no counter flops are synthesised.

Decomposition:
- Package l1_cache_pkg:
  - state_t enum {IDLE, WRITEBACK, FILL}.
  - writing encodings: WR_FILL = 2'b00, WR_CPU = 2'b01, WR_HOLD = 2'b10.
  - Geometry constants TAG_W = 23, IDX_W = 4, LINE_W = 256.
- One sub-module, l1_sat_counter (parameter W; ports clk, rst, inc, count), instantiated three times under the macro.

Test Plan:
- Reset: assert rst = 0 during WRITEBACK with pmem_write = 1 → next edge state IDLE; pmem_write = 0, writing = 10, mem_resp = 0.
- Read hit: mem_read = 1, hit = 1 → mem_resp = 1 same cycle, writing = 10, no loads; hit_count 0 → 1.
- Write hit: mem_write = 1, hit = 1 → mem_resp = 1, writing = 01, dirty_load = 1, dirty_in = 1 in that cycle.
- Clean read miss: hit = 0, dirty_out = 0, pmem_resp after 3 cycles →
  - pmem_read high 3 cycles.
  - Resp cycle: writing = 00 and tag/valid/dirty_load = 1 with dirty_in = 0.
  - With hit = 1 modelled, mem_resp one cycle later.
  - miss_count = 1.
- Dirty write miss: hit = 0, dirty_out = 1, wb resp after 2 cycles, fill resp after 2 cycles →
  - pmem_write phase, then dirty_load = 1 / dirty_in = 0, then pmem_read phase, then IDLE write with writing = 01.
  - mem_resp at cycle 5; wb_count = 1.
- Corner cases:
  - mem_read and mem_write both 1 on a hit → handled as write (writing = 01).
  - Stray pmem_resp in IDLE → no state change.
  - Request dropped during FILL → fill completes, no mem_resp.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// l1_cache_pkg: shared types and constants for the L1 cache controller.
//   state_t   : controller FSM states (IDLE, WRITEBACK, FILL)
//   WR_*      : encodings of the datapath 'writing' select
//   TAG_W, IDX_W, LINE_W : cache geometry (16 sets x 256-bit lines, 23-bit tag)
package l1_cache_pkg;

  localparam int TAG_W  = 23;
  localparam int IDX_W  = 4;
  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  localparam logic [1:0] WR_FILL = 2'b00;  // line data from pmem
  localparam logic [1:0] WR_CPU  = 2'b01;  // CPU byte-masked write merge
  localparam logic [1:0] WR_HOLD = 2'b10;  // keep line contents

endpackage

// File: rtl/l1_cache_control_if.sv
// l1_cache_control_if: CPU request, datapath control/status and pmem
// handshake signals of the L1 cache controller.
//   master : controller side (drives mem_resp, datapath loads, pmem requests)
//   slave  : environment side (CPU, datapath and pmem model)
interface l1_cache_control_if;

  // CPU side
  logic       mem_read;
  logic       mem_write;
  logic       mem_resp;
  // datapath status
  logic       hit;
  logic       dirty_out;
  // datapath controls
  logic       tag_load;
  logic       valid_load;
  logic       dirty_load;
  logic       dirty_in;
  logic [1:0] writing;
  // pmem handshake
  logic       pmem_read;
  logic       pmem_write;
  logic       pmem_resp;

  modport master (
    input  mem_read, mem_write, hit, dirty_out, pmem_resp,
    output mem_resp, tag_load, valid_load, dirty_load, dirty_in, writing,
           pmem_read, pmem_write
  );

  modport slave (
    output mem_read, mem_write, hit, dirty_out, pmem_resp,
    input  mem_resp, tag_load, valid_load, dirty_load, dirty_in, writing,
           pmem_read, pmem_write
  );

endinterface

// File: rtl/l1_sat_counter.sv
// l1_sat_counter: W-bit up counter that saturates at all-ones.
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active-low
//   inc   : increment enable
//   count : current value
module l1_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/l1_cache_control.sv
// l1_cache_control: FSM sequencer for the direct-mapped L1 cache datapath.
// Serves CPU reads/writes with 0-wait hits; on a miss writes back a dirty
// victim, then fills the line, then completes the still-held request as a hit.
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active-low
//   bus        : CPU / datapath / pmem signals (l1_cache_control_if.master)
//   hit_count  : requests completed without a miss
//   miss_count : requests that missed
//   wb_count   : write-backs issued
// Optional feature macro L1_CTRL_PERF_EN: when defined, the three counters
// are saturating CNT_W-bit counters; otherwise they are tied to zero.
module l1_cache_control
  import l1_cache_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  l1_cache_control_if.master    bus,
  output logic [CNT_W-1:0]      hit_count,
  output logic [CNT_W-1:0]      miss_count,
  output logic [CNT_W-1:0]      wb_count
);

  state_t     state_reg, state_next;
  logic       req;
  logic       mem_resp_c, tag_load_c, valid_load_c, dirty_load_c, dirty_in_c;
  logic       pmem_read_c, pmem_write_c;
  logic [1:0] writing_c;

  // A simultaneous read+write is served as a write.
  assign req = bus.mem_read | bus.mem_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mem_resp_c   = 1'b0;
    tag_load_c   = 1'b0;
    valid_load_c = 1'b0;
    dirty_load_c = 1'b0;
    dirty_in_c   = 1'b0;
    writing_c    = WR_HOLD;
    pmem_read_c  = 1'b0;
    pmem_write_c = 1'b0;
    // Outputs are Mealy; hold them at their idle values while in reset so
    // a held CPU request cannot produce a response during reset.
    if (rst) begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            if (bus.hit) begin
              mem_resp_c = 1'b1;
              if (bus.mem_write) begin
                writing_c    = WR_CPU;
                dirty_load_c = 1'b1;
                dirty_in_c   = 1'b1;
              end
            end else begin
              state_next = bus.dirty_out ? WRITEBACK : FILL;
            end
          end
        end
        WRITEBACK: begin
          pmem_write_c = 1'b1;
          if (bus.pmem_resp) begin
            // Clearing dirty steers the datapath pmem address to the CPU
            // address for the following fill.
            dirty_load_c = 1'b1;
            dirty_in_c   = 1'b0;
            state_next   = FILL;
          end
        end
        FILL: begin
          pmem_read_c = 1'b1;
          if (bus.pmem_resp) begin
            writing_c    = WR_FILL;
            tag_load_c   = 1'b1;
            valid_load_c = 1'b1;
            dirty_load_c = 1'b1;
            dirty_in_c   = 1'b0;
            state_next   = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign bus.mem_resp   = mem_resp_c;
  assign bus.tag_load   = tag_load_c;
  assign bus.valid_load = valid_load_c;
  assign bus.dirty_load = dirty_load_c;
  assign bus.dirty_in   = dirty_in_c;
  assign bus.writing    = writing_c;
  assign bus.pmem_read  = pmem_read_c;
  assign bus.pmem_write = pmem_write_c;

`ifdef L1_CTRL_PERF_EN
  logic             miss_start, wb_done, hit_done;
  logic             missed_reg, missed_next;
  logic [2:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [3];

  assign miss_start = (state_reg == IDLE) && (state_next != IDLE);
  assign wb_done    = (state_reg == WRITEBACK) && bus.pmem_resp && rst;
  // The response that follows a fill belongs to a missed request and must
  // not count as a hit.
  assign hit_done   = mem_resp_c && !missed_reg;

  // Set on a miss; every IDLE cycle clears it, so the flag lives exactly
  // until the first IDLE cycle after the fill (response or withdrawn).
  always_comb begin
    missed_next = missed_reg;
    if (state_reg == IDLE) begin
      missed_next = miss_start;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      missed_reg <= 1'b0;
    end else begin
      missed_reg <= missed_next;
    end
  end

  assign cnt_inc = {wb_done, miss_start, hit_done};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    l1_sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (cnt_inc[gi]),
      .count (cnt_val[gi])
    );
  end

  assign hit_count  = cnt_val[0];
  assign miss_count = cnt_val[1];
  assign wb_count   = cnt_val[2];
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_l1_cache_control.sv
// tb_l1_cache_control: directed self-checking bench for l1_cache_control.
// Output bundle order: {mem_resp, tag_load, valid_load, dirty_load,
// dirty_in, writing[1:0], pmem_read, pmem_write}.
module tb_l1_cache_control;

  localparam int CNT_W = 32;
`ifdef L1_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst;
  logic [CNT_W-1:0] hit_count, miss_count, wb_count;
  int n_cmp;
  int n_err;

  l1_cache_control_if bus ();

  l1_cache_control #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .wb_count   (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] eo(input logic resp, input logic tl, input logic vl,
                                    input logic dl, input logic di, input logic [1:0] wr,
                                    input logic pr, input logic pw);
    return {resp, tl, vl, dl, di, wr, pr, pw};
  endfunction

  function automatic logic [8:0] outs();
    return {bus.mem_resp, bus.tag_load, bus.valid_load, bus.dirty_load, bus.dirty_in,
            bus.writing, bus.pmem_read, bus.pmem_write};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_o(input string tag, input logic [8:0] exp);
    #1;
    check_eq(tag, {23'd0, outs()}, {23'd0, exp});
  endtask

  task automatic chk_cnt(input string tag, input int h, input int m, input int w);
    check_eq({tag, "_hit_count"},  hit_count,  PERF ? h : 0);
    check_eq({tag, "_miss_count"}, miss_count, PERF ? m : 0);
    check_eq({tag, "_wb_count"},   wb_count,   PERF ? w : 0);
  endtask

  logic [8:0] o_idle, o_rhit, o_whit, o_fillw, o_fillr, o_wbw, o_wbr;

  initial begin
    n_cmp = 0;
    n_err = 0;
    o_idle  = eo(0, 0, 0, 0, 0, 2'b10, 0, 0);
    o_rhit  = eo(1, 0, 0, 0, 0, 2'b10, 0, 0);
    o_whit  = eo(1, 0, 0, 1, 1, 2'b01, 0, 0);
    o_fillw = eo(0, 0, 0, 0, 0, 2'b10, 1, 0);
    o_fillr = eo(0, 1, 1, 1, 0, 2'b00, 1, 0);
    o_wbw   = eo(0, 0, 0, 0, 0, 2'b10, 0, 1);
    o_wbr   = eo(0, 0, 0, 1, 0, 2'b10, 0, 1);

    rst = 1'b0;
    bus.mem_read = 0; bus.mem_write = 0; bus.hit = 0; bus.dirty_out = 0; bus.pmem_resp = 0;
    tick(); tick();
    chk_o("reset_outs", o_idle);
    chk_cnt("reset", 0, 0, 0);
    rst = 1'b1;
    tick();
    $display("txn reset");

    // read hit
    bus.mem_read = 1; bus.hit = 1;
    chk_o("read_hit", o_rhit);
    tick();
    bus.mem_read = 0; bus.hit = 0;
    chk_o("read_hit_after", o_idle);
    chk_cnt("read_hit", 1, 0, 0);
    $display("txn read hit");

    // write hit
    bus.mem_write = 1; bus.hit = 1;
    chk_o("write_hit", o_whit);
    tick();
    bus.mem_write = 0; bus.hit = 0;
    chk_cnt("write_hit", 2, 0, 0);
    $display("txn write hit");

    // read and write together on a hit: write wins
    bus.mem_read = 1; bus.mem_write = 1; bus.hit = 1;
    chk_o("rw_both_hit", o_whit);
    tick();
    bus.mem_read = 0; bus.mem_write = 0; bus.hit = 0;
    $display("txn read+write hit");

    // stray pmem_resp in IDLE
    bus.pmem_resp = 1;
    chk_o("stray_resp", o_idle);
    tick();
    bus.pmem_resp = 0;
    chk_o("stray_resp_after", o_idle);
    chk_cnt("stray_resp", 3, 0, 0);
    $display("txn stray pmem_resp");

    // clean read miss, fill resp on the third FILL cycle
    bus.mem_read = 1; bus.hit = 0; bus.dirty_out = 0;
    chk_o("clean_c0", o_idle);
    tick();
    chk_o("clean_c1", o_fillw);
    tick();
    chk_o("clean_c2", o_fillw);
    tick();
    bus.pmem_resp = 1;
    chk_o("clean_c3_resp", o_fillr);
    tick();
    bus.pmem_resp = 0; bus.hit = 1;
    chk_o("clean_c4_memresp", o_rhit);
    tick();
    bus.mem_read = 0; bus.hit = 0;
    chk_o("clean_after", o_idle);
    chk_cnt("clean_miss", 3, 1, 0);
    $display("txn clean read miss");

    // dirty write miss: wb 2 cycles, fill 2 cycles, resp at cycle 5
    bus.mem_write = 1; bus.hit = 0; bus.dirty_out = 1;
    chk_o("dirty_c0", o_idle);
    tick();
    chk_o("dirty_c1", o_wbw);
    tick();
    bus.pmem_resp = 1;
    chk_o("dirty_c2_wbresp", o_wbr);
    tick();
    bus.pmem_resp = 0; bus.dirty_out = 0;
    chk_o("dirty_c3", o_fillw);
    tick();
    bus.pmem_resp = 1;
    chk_o("dirty_c4_fillresp", o_fillr);
    tick();
    bus.pmem_resp = 0; bus.hit = 1;
    chk_o("dirty_c5_memresp", o_whit);
    tick();
    bus.mem_write = 0; bus.hit = 0;
    chk_cnt("dirty_miss", 3, 2, 1);
    $display("txn dirty write miss");

    // request withdrawn during FILL
    bus.mem_read = 1; bus.hit = 0; bus.dirty_out = 0;
    chk_o("drop_c0", o_idle);
    tick();
    chk_o("drop_c1", o_fillw);
    bus.mem_read = 0;
    tick();
    bus.pmem_resp = 1;
    chk_o("drop_c2_resp", o_fillr);
    tick();
    bus.pmem_resp = 0;
    chk_o("drop_c3_noresp", o_idle);
    tick();
    chk_o("drop_c4_idle", o_idle);
    bus.mem_read = 1; bus.hit = 1;
    chk_o("drop_then_hit", o_rhit);
    tick();
    bus.mem_read = 0; bus.hit = 0;
    chk_cnt("drop", 4, 3, 1);
    $display("txn dropped request");

    // reset asserted mid write-back
    bus.mem_write = 1; bus.hit = 0; bus.dirty_out = 1;
    tick();
    chk_o("rst_wb_active", o_wbw);
    rst = 1'b0;
    chk_o("rst_wb_idle", o_idle);
    chk_cnt("rst_wb", 0, 0, 0);
    tick();
    bus.mem_write = 0; bus.dirty_out = 0;
    rst = 1'b1;
    tick();
    bus.pmem_resp = 1;
    chk_o("rst_wb_abandon", o_idle);
    tick();
    bus.pmem_resp = 0;
    chk_o("rst_wb_after", o_idle);
    $display("txn reset mid write-back");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
